// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: store FIFO plus load/store arbiter in front of a single-port data memory
// Ports: i_clk, i_reset (sync, active-low); store request i_st_* / o_st_ready;
//   load request i_ld_* / o_ld_stall; memory port o_mem_*; o_empty (fence); o_misalign_err.
// Optional macro LSU_MISALIGN_EN: enqueue word-crossing stores instead of rejecting them.
module lsu_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_st_valid,
  input  logic [2:0]    i_st_func3,
  input  logic [AW-1:0] i_st_addr,
  input  logic [31:0]   i_st_wdata,
  output logic          o_st_ready,
  input  logic          i_ld_valid,
  input  logic [2:0]    i_ld_func3,
  input  logic [AW-1:0] i_ld_addr,
  output logic          o_ld_stall,
  output logic          o_mem_wren,
  output logic [2:0]    o_mem_func3,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask_align,
  output logic [3:0]    o_mem_bmask_misalign,
  output logic          o_empty,
  output logic          o_misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - 2;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic [AW-1:0]    q_addr  [DEPTH];
  logic [31:0]      q_wdata [DEPTH];
  logic [2:0]       q_func3 [DEPTH];
  logic [3:0]       q_align [DEPTH];
  logic [3:0]       q_mis   [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] ent_hit;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic [7:0]       st_span;
  logic [2:0]       ld_last;
  logic [WW-1:0]    ld_word, ld_word1;
  logic             ready, st_legal, st_cross, enq, hit, ld_cross, drain, misalign_q;
  // byte lanes covered by an access of 1/2/4 bytes, shifted by offset into a two-word window
  function automatic logic [7:0] span(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    m = sz == 2'd0 ? 4'b0001 : sz == 2'd1 ? 4'b0011 : 4'b1111;
    return {4'b0000, m} << off;
  endfunction
  assign st_span  = span(i_st_func3[1:0], i_st_addr[1:0]);
  assign st_legal = !i_st_func3[2] && i_st_func3[1:0] != 2'b11;
  assign st_cross = |st_span[7:4];
  assign ready    = count != DEPTH[PW:0];
  assign enq      = i_reset && i_st_valid && ready && st_legal && (MIS_EN || !st_cross);
  assign ld_last  = i_ld_func3[1:0] == 2'd0 ? 3'd0 : i_ld_func3[1:0] == 2'd1 ? 3'd1 : 3'd3;
  assign ld_cross = ({1'b0, i_ld_addr[1:0]} + ld_last) > 3'd3;
  assign ld_word  = i_ld_addr[AW-1:2];
  assign ld_word1 = ld_word + WW'(1);
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [WW-1:0] w, w1;
    assign w  = q_addr[i][AW-1:2];
    assign w1 = w + WW'(1);
    assign ent_hit[i] = q_vld[i] && (w == ld_word || (ld_cross && w == ld_word1) ||
                        (|q_mis[i] && w1 == ld_word));
  end
  assign hit   = i_ld_valid && |ent_hit;
  // a load that conflicts with a pending store yields the port so the store can drain
  assign drain = i_reset && !(i_ld_valid && !hit) && q_vld[head];
  assign o_st_ready           = !i_reset || ready;
  assign o_empty              = !i_reset || count == '0;
  assign o_ld_stall           = i_reset && hit;
  assign o_mem_wren           = drain;
  assign o_mem_addr           = drain ? q_addr[head] : i_ld_addr;
  assign o_mem_func3          = drain ? q_func3[head] : i_ld_func3;
  assign o_mem_wdata          = drain ? q_wdata[head] : 32'd0;
  assign o_mem_bmask_align    = drain ? q_align[head] : 4'd0;
  assign o_mem_bmask_misalign = drain ? q_mis[head] : 4'd0;
  assign o_misalign_err       = i_reset && misalign_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      q_vld      <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (enq) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (drain) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      count      <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
      misalign_q <= !MIS_EN && i_st_valid && ready && st_legal && st_cross;
    end
  end
  always_ff @(posedge i_clk) begin
    if (enq) begin
      q_addr[tail]  <= i_st_addr;
      q_wdata[tail] <= i_st_wdata;
      q_func3[tail] <= i_st_func3;
      q_align[tail] <= st_span[3:0];
      q_mis[tail]   <= st_span[7:4] & {4{MIS_EN}};
    end
  end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb_lsu_store_buffer: directed and random stimulus against a queue-based reference model
module tb_lsu_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_st_valid = 1'b0;
  logic [2:0]  i_st_func3 = '0;
  logic [15:0] i_st_addr = '0;
  logic [31:0] i_st_wdata = '0;
  logic        i_ld_valid = 1'b0;
  logic [2:0]  i_ld_func3 = '0;
  logic [15:0] i_ld_addr = '0;
  logic        o_st_ready, o_ld_stall, o_mem_wren, o_empty, o_misalign_err;
  logic [2:0]  o_mem_func3;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask_align, o_mem_bmask_misalign;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [3:0]  al;
    logic [3:0]  mi;
  } ent_t;
  ent_t sb[$];
  bit err_pend = 0;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  lsu_store_buffer #(.DEPTH(DEPTH), .AW(16)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_st_valid(i_st_valid), .i_st_func3(i_st_func3), .i_st_addr(i_st_addr),
    .i_st_wdata(i_st_wdata), .o_st_ready(o_st_ready),
    .i_ld_valid(i_ld_valid), .i_ld_func3(i_ld_func3), .i_ld_addr(i_ld_addr),
    .o_ld_stall(o_ld_stall), .o_mem_wren(o_mem_wren), .o_mem_func3(o_mem_func3),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask_align(o_mem_bmask_align), .o_mem_bmask_misalign(o_mem_bmask_misalign),
    .o_empty(o_empty), .o_misalign_err(o_misalign_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // {align, misalign} straight from the encoding table; 0 for illegal func3
  function automatic logic [7:0] masks(input logic [2:0] f, input logic [1:0] o);
    case ({f, o})
      5'b000_00: return 8'b0001_0000;
      5'b000_01: return 8'b0010_0000;
      5'b000_10: return 8'b0100_0000;
      5'b000_11: return 8'b1000_0000;
      5'b001_00: return 8'b0011_0000;
      5'b001_01: return 8'b0110_0000;
      5'b001_10: return 8'b1100_0000;
      5'b001_11: return 8'b1000_0001;
      5'b010_00: return 8'b1111_0000;
      5'b010_01: return 8'b1110_0001;
      5'b010_10: return 8'b1100_0011;
      5'b010_11: return 8'b1000_0111;
      default:   return 8'b0000_0000;
    endcase
  endfunction
  function automatic bit overlap(input ent_t e, input logic [15:0] la, input logic [2:0] lf);
    int w0 = int'(e.addr) / 4;
    int w1 = (e.mi != 0) ? (w0 + 1) % 16384 : w0;
    int l0 = int'(la) / 4;
    int nb = lf[1:0] == 2'd0 ? 1 : lf[1:0] == 2'd1 ? 2 : 4;
    int l1 = (int'(la) % 4 + nb > 4) ? (l0 + 1) % 16384 : l0;
    return w0 == l0 || w0 == l1 || w1 == l0 || w1 == l1;
  endfunction
  task automatic cycle(input bit rst, input bit sv, input logic [2:0] sf, input logic [15:0] sa,
                       input logic [31:0] sd, input bit lv, input logic [2:0] lf,
                       input logic [15:0] la);
    bit hit, drain, rdy;
    logic [7:0] m;
    @(negedge clk);
    i_reset = rst; i_st_valid = sv; i_st_func3 = sf; i_st_addr = sa; i_st_wdata = sd;
    i_ld_valid = lv; i_ld_func3 = lf; i_ld_addr = la;
    #1;
    if (!rst) begin
      check("rst_wren", o_mem_wren, 0);
      check("rst_ready", o_st_ready, 1);
      check("rst_empty", o_empty, 1);
      check("rst_stall", o_ld_stall, 0);
      check("rst_err", o_misalign_err, 0);
      sb.delete();
      err_pend = 0;
      return;
    end
    hit = 0;
    foreach (sb[k]) if (overlap(sb[k], la, lf)) hit = 1;
    hit = hit && lv;
    drain = !(lv && !hit) && sb.size() > 0;
    rdy = sb.size() < DEPTH;
    check("ready", o_st_ready, rdy);
    check("empty", o_empty, sb.size() == 0);
    check("stall", o_ld_stall, hit);
    check("err", o_misalign_err, err_pend);
    check("wren", o_mem_wren, drain);
    if (drain) begin
      check("w_addr", o_mem_addr, sb[0].addr);
      check("w_data", o_mem_wdata, sb[0].data);
      check("w_func3", o_mem_func3, sb[0].f3);
      check("w_align", o_mem_bmask_align, sb[0].al);
      check("w_mis", o_mem_bmask_misalign, sb[0].mi);
      void'(sb.pop_front());
    end else begin
      check("ld_addr", o_mem_addr, la);
      check("ld_func3", o_mem_func3, lf);
    end
    m = masks(sf, sa[1:0]);
    err_pend = 0;
    if (sv && rdy && sf <= 3'd2) begin
      if (m[3:0] == 4'd0 || MIS_EN)
        sb.push_back('{addr: sa, data: sd, f3: sf, al: m[7:4], mi: m[3:0]});
      else
        err_pend = 1;
    end
  endtask
  task automatic idle();
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 0, 3'd0, 16'h0);
  endtask
  initial begin
    repeat (3) cycle(0, 1, 3'd2, 16'h0004, 32'h1, 1, 3'd2, 16'h0008);
    cycle(1, 1, 3'd2, 16'h0010, 32'hDEADBEEF, 0, 3'd0, 16'h0);
    idle();
    idle();
    for (int k = 0; k < 5; k++)
      cycle(1, 1, 3'd0, 16'h0040 + 16'(k), 32'(k + 8'hA0), 1, 3'd2, 16'h0100);
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 1, 3'd2, 16'h0100);
    repeat (5) idle();
    cycle(1, 1, 3'd2, 16'h0020, 32'h11223344, 0, 3'd0, 16'h0);
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 1, 3'd2, 16'h0020);
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 1, 3'd2, 16'h0020);
    cycle(1, 1, 3'd1, 16'h0013, 32'h0000ABCD, 0, 3'd0, 16'h0);
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 1, 3'd2, 16'h0014);
    repeat (3) idle();
    cycle(1, 1, 3'd0, 16'h0050, 32'h1, 1, 3'd2, 16'h0200);
    cycle(1, 1, 3'd0, 16'h0051, 32'h2, 1, 3'd2, 16'h0200);
    for (int k = 0; k < 8; k++)
      cycle(1, 1, 3'd2, 16'h0060 + 16'(4 * k), 32'hC0DE0000 + 32'(k), 0, 3'd0, 16'h0);
    repeat (3) idle();
    for (int k = 0; k < 3; k++)
      cycle(1, 1, 3'd1, 16'h0070 + 16'(2 * k), 32'(k), 1, 3'd2, 16'h0300);
    cycle(0, 0, 3'd0, 16'h0, 32'h0, 0, 3'd0, 16'h0);
    idle();
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] sa, la;
      int pick = $urandom_range(0, 4);
      sa = ($urandom_range(0, 3) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                                        : 16'($urandom_range(0, 63));
      la = ($urandom_range(0, 3) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                                        : 16'($urandom_range(0, 63));
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
            sa, $urandom, $urandom_range(0, 9) < ((n % 200 < 100) ? 3 : 8),
            pick < 3 ? 3'(pick) : 3'(pick + 1), la);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Load/store front end that sits directly upstream of the data memory and drives its single address port, write enable, func3 and byte masks.
- Stores from the core are decoded into aligned and misaligned byte masks, then queued in a DEPTH-entry FIFO.
- Queued stores drain to memory one per cycle whenever the memory port is not taken by a load.
- Loads that overlap a pending store stall until that store has drained.

Parameters:
DEPTH, 4, number of store-buffer entries; power of two, at least 2
AW, 16, byte address width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-low reset
i_st_valid  in  1  store request
i_st_func3  in  3  000 SB, 001 SH, 010 SW
i_st_addr  in  AW  store byte address
i_st_wdata  in  32  store data, right-justified
o_st_ready  out  1  buffer can accept a store this cycle
i_ld_valid  in  1  load request
i_ld_func3  in  3  load func3, passed through to memory
i_ld_addr  in  AW  load byte address
o_ld_stall  out  1  load must hold; retry next cycle
o_mem_wren  out  1  memory write enable
o_mem_func3  out  3  func3 to memory
o_mem_addr  out  AW  address to memory
o_mem_wdata  out  32  store data to memory
o_mem_bmask_align  out  4  byte mask for word addr[AW-1:2]
o_mem_bmask_misalign  out  4  byte mask for word addr[AW-1:2]+1
o_empty  out  1  no pending stores, used for fence
o_misalign_err  out  1  dropped misaligned store, one-cycle pulse

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset, sampled on posedge i_clk.
- Reset values: while i_reset=0 the head/tail pointers and count clear to 0.
  - Also held during reset: o_mem_wren=0, o_st_ready=1, o_empty=1, o_ld_stall=0, o_misalign_err=0.
  - Reset asserted mid-drain discards all pending entries; no write is issued in that cycle.
- Mask encoding, by func3 and addr[1:0], given as align mask / misalign mask:
  - SB at offset k: align 1<<k, misalign 0000.
  - SH: offset 0 gives 0011/0000; offset 1 gives 0110/0000; offset 2 gives 1100/0000; offset 3 gives 1000/0001.
  - SW: offset 0 gives 1111/0000; offset 1 gives 1110/0001; offset 2 gives 1100/0011; offset 3 gives 1000/0111.
  - Any other func3: request accepted and dropped, no enqueue, no error.
- Each entry stores addr, wdata, func3, align mask and misalign mask.
- Enqueue: on i_st_valid & o_st_ready; the entry is visible to drain from the next cycle.
- o_st_ready = count<DEPTH, combinational from registered count only. Drain in the same cycle does not free space early.
- Port arbitration each cycle, combinational:
  - (a) i_ld_valid and no hit: the load owns the port. o_mem_addr=i_ld_addr, o_mem_func3=i_ld_func3, o_mem_wren=0, o_ld_stall=0, no drain.
  - (b) Otherwise, if the FIFO is not empty: drain the head. o_mem_wren=1 and o_mem_* are taken from the head entry, and the head pops at the clock edge.
  - (c) Otherwise: o_mem_wren=0, o_mem_addr=i_ld_addr.
- Hit: i_ld_valid and any valid entry whose word range {W, W+1 if its misalign mask is nonzero} intersects the load word range {L, L+1 if the load crosses a word}, where W and L are addr[AW-1:2].
  - On a hit: o_ld_stall=1 and the head drains (rule b). This guarantees forward progress.
- Word+1 computation wraps modulo 2^(AW-2).
- Simultaneous enqueue and drain: count is unchanged and pointers advance independently, wrapping modulo DEPTH.
- A store to the same word as an older entry is queued behind it; drain order is strict FIFO.
- o_empty = (count==0).
- Latency: a store reaches memory no earlier than 1 cycle after acceptance. An unhindered load sees the memory's combinational read in the same cycle.

Optional Feature:
LSU_MISALIGN_EN
- Defined: word-crossing stores (SH offset 3; SW offset 1-3) enqueue with the misalign masks above. o_misalign_err is tied to 0.
- Undefined: word-crossing stores are not enqueued. o_misalign_err is a registered pulse one cycle after the rejected request, and o_st_ready is unaffected. Stored misalign masks are always 0000.

Test Plan:
- Reset, then SW 0xDEADBEEF to addr 0x0010 with no loads -> next cycle o_mem_wren=1, addr 0x0010, masks 1111/0000, wdata 0xDEADBEEF; o_empty=1 the cycle after.
- Hold i_ld_valid at a non-overlapping addr 0x0100 while issuing DEPTH=4 SB stores -> o_st_ready=0 after the 4th; no write occurs while the loads continue; on release, 4 writes issue in order on consecutive cycles.
- SW 0x11223344 to 0x0020, then LW at 0x0020 the next cycle -> o_ld_stall=1 for 1 cycle while the write drains; stall=0 the following cycle.
- SH to 0x0013 with LSU_MISALIGN_EN -> masks 1000/0001; LW at 0x0014 stalls (hit on W+1). Without the macro -> no write, o_misalign_err=1 for one cycle.
- Enqueue and drain in the same cycle at count=2 -> count stays 2; 8 consecutive stores drain correctly across pointer wrap.
- Assert i_reset=0 with 3 entries pending -> o_mem_wren=0 that cycle; afterward o_empty=1 and o_st_ready=1.
